// File: rtl/pkg_system_mdr.sv
// Shared definitions for the sequential restoring divider.
// Holds the operand width, the operand and counter types, and the FSM state encoding.
// No ports; imported by div_seq, div_step and div_seq_if.
package pkg_system_mdr;

  localparam int DW = 8;
  localparam int CW = $clog2(DW) + 1;

  typedef logic [DW-1:0] data_in_t;
  typedef logic [CW-1:0] counter_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between a divider client and div_seq.
// master drives i_start/i_dividend/i_divisor and observes every o_* signal;
// slave (the divider) is the mirror image. Start is a request-only handshake gated by o_ready.
interface div_seq_if #(
  parameter int DW = pkg_system_mdr::DW
);
  localparam int CW = $clog2(DW) + 1;

  logic          i_start;
  logic [DW-1:0] i_dividend;
  logic [DW-1:0] i_divisor;
  logic          o_ready;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [DW-1:0] o_quotient;
  logic [DW-1:0] o_remainder;
  logic [CW-1:0] o_counter;
  logic          o_enable;
  logic          o_flag;

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_ready, o_busy, o_done, o_err, o_quotient, o_remainder,
           o_counter, o_enable, o_flag
  );

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_ready, o_busy, o_done, o_err, o_quotient, o_remainder,
           o_counter, o_enable, o_flag
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational (zero latency); no handshake.
// Ports: rem (partial remainder), din (next dividend bit), divisor -> next_rem, flag (1 = subtract taken).
module div_step #(
  parameter int DW = pkg_system_mdr::DW
) (
  input  logic [DW-1:0] rem,
  input  logic          din,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] next_rem,
  output logic          flag
);

  logic [DW-1:0] shifted;
  logic [DW+1:0] trial;
  logic          unused_trial_bit;

  // rem < divisor always holds, so when the subtract is not taken the shifted
  // value still fits in DW bits and dropping rem's MSB loses nothing.
  assign shifted = {rem[DW-2:0], din};

  // {rem, din} can need DW+1 bits; one extra guard bit on top carries the sign.
  assign trial = {1'b0, rem, din} - {2'b0, divisor};

  // A non-negative difference is always < divisor, so its low DW bits are exact.
  assign unused_trial_bit = trial[DW];
  assign flag     = ~trial[DW+1];
  assign next_rem = flag ? trial[DW-1:0] : shifted;

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider: IDLE -> RUN (DW iterations) -> DONE (one-cycle o_done pulse).
// Latency: start accepted at edge 0 gives o_done in cycle DW+1, or cycle 1 for a zero divisor.
// Backpressure: i_start is honoured only while o_ready; starts in RUN/DONE are dropped, never queued.
// Ports: clk, rst (sync, active high), bus (div_seq_if.slave: operands in, results/status out).
module div_seq #(
  parameter int DW = pkg_system_mdr::DW
) (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus
);
  import pkg_system_mdr::*;

  localparam int CW = $clog2(DW) + 1;

  div_state_t    state_q, state_nxt;
  logic [DW-1:0] dvd_q;      // latched dividend, shifted left so the next bit sits at the MSB
  logic [DW-1:0] dsr_q;
  logic [DW-1:0] rem_q;
  logic [DW-1:0] quo_q;
  logic [CW-1:0] cnt_q;
  logic          flag_q;
  logic          err_q;
  logic [DW-1:0] step_rem;
  logic          step_flag;
  logic          last_iter;

  assign last_iter = (cnt_q == CW'(DW - 1));

  div_step #(.DW(DW)) u_step (
    .rem      (rem_q),
    .din      (dvd_q[DW-1]),
    .divisor  (dsr_q),
    .next_rem (step_rem),
    .flag     (step_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) state_nxt = (bus.i_divisor == '0) ? DONE : RUN;
      end
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            dvd_q <= bus.i_dividend;
            dsr_q <= bus.i_divisor;
            cnt_q <= '0;
            // A zero divisor skips RUN, so its fixed result is loaded right
            // away to be valid in the DONE cycle that follows.
            if (bus.i_divisor == '0) begin
              err_q <= 1'b1;
              quo_q <= '1;
              rem_q <= bus.i_dividend;
            end else begin
              err_q <= 1'b0;
              quo_q <= '0;
              rem_q <= '0;
            end
          end
        end
        RUN: begin
          rem_q  <= step_rem;
          quo_q  <= {quo_q[DW-2:0], step_flag};
          flag_q <= step_flag;
          dvd_q  <= {dvd_q[DW-2:0], 1'b0};
          cnt_q  <= last_iter ? '0 : cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready     = (state_q == IDLE);
  assign bus.o_busy      = (state_q == RUN);
  assign bus.o_enable    = (state_q == RUN);
  assign bus.o_done      = (state_q == DONE);
  assign bus.o_err       = err_q;
  assign bus.o_quotient  = quo_q;
  assign bus.o_remainder = rem_q;
  assign bus.o_counter   = cnt_q;
  assign bus.o_flag      = flag_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq (DW=8): directed cases plus a randomized sweep
// compared against plain integer division and the cycle timing of the handshake.
// Ports: none (top level); instantiates div_seq_if and div_seq.
module tb_div_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_seq_if #(.DW(W)) bus ();
  div_seq #(.DW(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Runs one division from IDLE. Reports the first o_done cycle (0 = never seen),
  // captured results, number of o_done pulses, count of set o_flag values seen
  // after each iteration, and how many cycles broke the expected sequencing.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit repulse,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic e,
                        output int done_cyc, output int n_done, output int flag_cnt,
                        output int seq_bad);
    int expd;
    expd = (b == 0) ? 1 : W + 1;
    q = '0; r = '0; e = 1'b0;
    done_cyc = 0; n_done = 0; flag_cnt = 0; seq_bad = 0;
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.i_start    = 1'b0;
        bus.i_dividend = W'($urandom);
        bus.i_divisor  = W'($urandom);
      end
      if (repulse && c == 3) begin
        bus.i_start    = 1'b1;
        bus.i_dividend = W'($urandom);
        bus.i_divisor  = W'($urandom_range(1, 255));
      end
      if (repulse && c == 4) bus.i_start = 1'b0;

      if (bus.o_done === 1'b1) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = c;
          q = bus.o_quotient;
          r = bus.o_remainder;
          e = bus.o_err;
        end
      end
      if (c >= 2 && (done_cyc == 0 || done_cyc == c) && bus.o_flag === 1'b1) flag_cnt++;

      if (b != 0 && c <= W) begin
        if ({bus.o_ready, bus.o_busy, bus.o_enable, bus.o_done, bus.o_counter} !==
            {1'b0, 1'b1, 1'b1, 1'b0, 4'(c - 1)}) seq_bad++;
      end
      if (c == expd) begin
        if ({bus.o_ready, bus.o_busy, bus.o_enable, bus.o_counter} !== {3'b000, 4'd0}) seq_bad++;
      end
      if (c == expd + 1) begin
        if ({bus.o_ready, bus.o_busy, bus.o_done, bus.o_counter} !== {3'b100, 4'd0}) seq_bad++;
        if ({bus.o_quotient, bus.o_remainder, bus.o_err} !== {q, r, e}) seq_bad++;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready);
    end
    n_checks++;
    if ({bus.o_busy, bus.o_done, bus.o_err, bus.o_flag, bus.o_enable} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=00000",
        {bus.o_busy, bus.o_done, bus.o_err, bus.o_flag, bus.o_enable});
    end
    n_checks++;
    if ({bus.o_quotient, bus.o_remainder, bus.o_counter} !== '0) begin
      n_fail++; $display("FAIL reset_data got q=%0d r=%0d cnt=%0d exp 0/0/0",
        bus.o_quotient, bus.o_remainder, bus.o_counter);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r; logic e; int dc, nd, fc, sb;
    do_div(8'd100, 8'd7, 1'b0, q, r, e, dc, nd, fc, sb);
    n_checks++;
    if (dc !== 9) begin n_fail++; $display("FAIL basic_latency got=%0d exp=9", dc); end
    n_checks++;
    if ({q, r, e} !== {8'd14, 8'd2, 1'b0}) begin
      n_fail++; $display("FAIL basic_result got q=%0d r=%0d e=%b exp 14/2/0", q, r, e);
    end
    n_checks++;
    if (sb !== 0) begin n_fail++; $display("FAIL basic_sequence bad_cycles=%0d exp=0", sb); end
  endtask

  task automatic test_all_ones();
    logic [W-1:0] q, r; logic e; int dc, nd, fc, sb;
    do_div(8'd255, 8'd1, 1'b0, q, r, e, dc, nd, fc, sb);
    n_checks++;
    if ({q, r, e} !== {8'd255, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL ones_result got q=%0d r=%0d e=%b exp 255/0/0", q, r, e);
    end
    n_checks++;
    if (fc !== 8) begin n_fail++; $display("FAIL ones_flag_count got=%0d exp=8", fc); end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r; logic e; int dc, nd, fc, sb;
    do_div(8'd5, 8'd0, 1'b0, q, r, e, dc, nd, fc, sb);
    n_checks++;
    if (dc !== 1) begin n_fail++; $display("FAIL zero_latency got=%0d exp=1", dc); end
    n_checks++;
    if ({q, r, e} !== {8'd255, 8'd5, 1'b1}) begin
      n_fail++; $display("FAIL zero_result got q=%0d r=%0d e=%b exp 255/5/1", q, r, e);
    end
    n_checks++;
    if (sb !== 0) begin n_fail++; $display("FAIL zero_sequence bad_cycles=%0d exp=0", sb); end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] q, r; logic e; int dc, nd, fc, sb;
    do_div(8'd3, 8'd200, 1'b1, q, r, e, dc, nd, fc, sb);
    n_checks++;
    if ({q, r, e} !== {8'd0, 8'd3, 1'b0}) begin
      n_fail++; $display("FAIL ignore_result got q=%0d r=%0d e=%b exp 0/3/0", q, r, e);
    end
    n_checks++;
    if (nd !== 1 || sb !== 0) begin
      n_fail++; $display("FAIL ignore_single_done got done_pulses=%0d bad_cycles=%0d exp 1/0", nd, sb);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r; logic e; int dc, nd, fc, sb;
    bit saw_done, reached;
    saw_done = 1'b0; reached = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_dividend = 8'd200; bus.i_divisor = 8'd9;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_done === 1'b1) saw_done = 1'b1;
      if (bus.o_counter === 4'd4 && bus.o_busy === 1'b1) begin reached = 1'b1; break; end
    end
    n_checks++;
    if (!reached) begin n_fail++; $display("FAIL midreset_reach got=0 exp=1 (iteration 4 not seen)"); end
    rst = 1'b1;
    @(negedge clk);
    if (bus.o_done === 1'b1) saw_done = 1'b1;
    n_checks++;
    if ({bus.o_ready, bus.o_busy, bus.o_enable, bus.o_flag, bus.o_err, bus.o_quotient,
         bus.o_remainder, bus.o_counter} !== {5'b10000, 20'd0}) begin
      n_fail++; $display("FAIL midreset_state got rdy=%b busy=%b q=%0d r=%0d cnt=%0d exp 1/0/0/0/0",
        bus.o_ready, bus.o_busy, bus.o_quotient, bus.o_remainder, bus.o_counter);
    end
    // Start requested while reset is still held must be dropped.
    bus.i_start = 1'b1; bus.i_dividend = 8'd50; bus.i_divisor = 8'd3;
    @(negedge clk);
    if (bus.o_done === 1'b1) saw_done = 1'b1;
    n_checks++;
    if ({bus.o_ready, bus.o_busy} !== 2'b10) begin
      n_fail++; $display("FAIL midreset_priority got rdy=%b busy=%b exp 1/0", bus.o_ready, bus.o_busy);
    end
    bus.i_start = 1'b0;
    rst = 1'b0;
    n_checks++;
    if (saw_done) begin n_fail++; $display("FAIL midreset_no_done got=1 exp=0"); end
    do_div(8'd200, 8'd9, 1'b0, q, r, e, dc, nd, fc, sb);
    n_checks++;
    if ({q, r, e} !== {8'd22, 8'd2, 1'b0} || dc !== 9) begin
      n_fail++; $display("FAIL midreset_rerun got q=%0d r=%0d e=%b cyc=%0d exp 22/2/0/9", q, r, e, dc);
    end
  endtask

  task automatic test_random(input int n);
    logic [W-1:0] a, b, q, r, eq, er; logic e, ee; int dc, nd, fc, sb, expd;
    for (int i = 0; i < n; i++) begin
      a = W'($urandom);
      b = (i % 16 == 0) ? 8'd0 : ((i % 4 == 1) ? W'($urandom_range(1, 15)) : W'($urandom));
      if (b == 0) begin eq = 8'd255; er = a; ee = 1'b1; expd = 1; end
      else begin eq = a / b; er = a % b; ee = 1'b0; expd = W + 1; end
      do_div(a, b, 1'b0, q, r, e, dc, nd, fc, sb);
      n_checks++;
      if ({q, r, e} !== {eq, er, ee} || dc !== expd) begin
        n_fail++; $display("FAIL rand_result %0d/%0d got q=%0d r=%0d e=%b cyc=%0d exp %0d/%0d/%b/%0d",
          a, b, q, r, e, dc, eq, er, ee, expd);
      end
      if (b != 0) begin
        n_checks++;
        if (32'(q) * 32'(b) + 32'(r) != 32'(a) || r >= b) begin
          n_fail++; $display("FAIL rand_identity %0d/%0d got q=%0d r=%0d", a, b, q, r);
        end
        n_checks++;
        if (fc != $countones(eq)) begin
          n_fail++; $display("FAIL rand_flags %0d/%0d got=%0d exp=%0d", a, b, fc, $countones(eq));
        end
      end
      n_checks++;
      if (sb !== 0 || nd !== 1) begin
        n_fail++; $display("FAIL rand_sequence %0d/%0d bad_cycles=%0d done_pulses=%0d exp 0/1", a, b, sb, nd);
      end
    end
  endtask

  initial begin
    bus.i_start    = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    test_reset();
    test_basic();
    test_all_ones();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
